// File: rtl/fb_write_scheduler_if.sv
// Frame-buffer write bus between the drawing engines and the write scheduler.
// The master side is the pair of pixel writers; the slave side is the scheduler.
interface fb_write_scheduler_if #(
    parameter int unsigned AW = 19,
    parameter int unsigned DW = 24
) ();
    logic          req0;
    logic          req1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] data0;
    logic [DW-1:0] data1;
    logic          ack0;
    logic          ack1;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    modport master (
        output req0, req1, addr0, addr1, data0, data1,
        input  ack0, ack1, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  req0, req1, addr0, addr1, data0, data1,
        output ack0, ack1, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/fb_write_scheduler.sv
// Round-robin arbiter for the frame-buffer write port, limited to LCD blanking
// with a per-line write budget, plus a registered frame-start strobe.
module fb_write_scheduler #(
    parameter int unsigned H_LINE       = 100,
    parameter int unsigned V_LINE       = 40,
    parameter int unsigned H_ACTIVE     = 80,
    parameter int unsigned V_ACTIVE     = 32,
    parameter int unsigned MAX_PER_LINE = 4,
    parameter int unsigned AW           = 19,
    parameter int unsigned DW           = 24
) (
    input  logic                 iCLK,
    input  logic                 iRST_n,
    input  logic [10:0]          x_cnt,
    input  logic [9:0]           y_cnt,
    fb_write_scheduler_if.slave  bus,
    output logic                 frame_start
);
    localparam logic [10:0] X_LAST  = 11'(H_LINE - 1);
    localparam logic [9:0]  Y_LAST  = 10'(V_LINE - 1);
    localparam logic [10:0] X_ACT   = 11'(H_ACTIVE);
    localparam logic [9:0]  Y_ACT   = 10'(V_ACTIVE);
    localparam logic [7:0]  MAX_CNT = 8'(MAX_PER_LINE);

    logic          ack0_q;
    logic          ack1_q;
    logic          wr_en_q;
    logic [AW-1:0] wr_addr_q;
    logic [DW-1:0] wr_data_q;
    logic          rr;
    logic [7:0]    line_cnt;

    logic [9:0]    nx_y_c;
    logic          blank_c;
    logic          guard_c;
    logic          window_c;
    logic          elig0_c;
    logic          elig1_c;
    logic          gnt0_c;
    logic          gnt1_c;

    // Write window and grant selection for the coming edge
    always_comb begin
        nx_y_c   = (y_cnt == Y_LAST) ? 10'd0 : y_cnt + 10'd1;
        blank_c  = (x_cnt >= X_ACT) || (y_cnt >= Y_ACT);
        guard_c  = (x_cnt == X_LAST) && (nx_y_c < Y_ACT);
        window_c = blank_c && !guard_c && (line_cnt < MAX_CNT);
        // A requester whose ack is showing still holds req for the old write
        elig0_c  = bus.req0 && !ack0_q;
        elig1_c  = bus.req1 && !ack1_q;
        gnt0_c   = window_c && elig0_c && (!elig1_c || !rr);
        gnt1_c   = window_c && elig1_c && (!elig0_c ||  rr);
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rr          <= 1'b0;
            line_cnt    <= 8'd0;
            frame_start <= 1'b0;
        end else begin
            ack0_q      <= gnt0_c;
            ack1_q      <= gnt1_c;
            wr_en_q     <= gnt0_c || gnt1_c;
            frame_start <= (x_cnt == 11'd0) && (y_cnt == 10'd0);

            if (gnt0_c) begin
                wr_addr_q <= bus.addr0;
                wr_data_q <= bus.data0;
                rr        <= 1'b1;
            end else if (gnt1_c) begin
                wr_addr_q <= bus.addr1;
                wr_data_q <= bus.data1;
                rr        <= 1'b0;
            end

            // A grant on the last pixel of a line is charged to the next line
            if (x_cnt == X_LAST) begin
                line_cnt <= (gnt0_c || gnt1_c) ? 8'd1 : 8'd0;
            end else if (gnt0_c || gnt1_c) begin
                line_cnt <= line_cnt + 8'd1;
            end
        end
    end

    assign bus.ack0    = ack0_q;
    assign bus.ack1    = ack1_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
endmodule
